csoc_scan_driver: RTL and testbench

- Pin-level scan sequencer between the command parser and the CSoC test pins.
- Accepts shift, capture and pin-level commands from the parser.
- For each shift, consumes one 8-bit slice (bit i feeds chain i) and drives it onto csoc_data_o, then pulses csoc_clk with csoc_test_se=1.
- Returns the sampled scan-out slice on a byte stream back to the parser for UART transmission.

---
 rtl/csoc_scan_defs.sv | 27 ++
 rtl/csoc_phase_timer.sv | 41 ++++
 rtl/csoc_scan_driver.sv | 257 +++++++++++++++++++++++++
 tb/tb_csoc_scan_driver.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csoc_scan_defs.sv
// Shared definitions for the CSoC scan driver: command opcodes, FSM state
// encoding and the default csoc_clk phase length.
package csoc_scan_defs;

    localparam logic [1:0] OP_SHIFT    = 2'b00;
    localparam logic [1:0] OP_CAPTURE  = 2'b01;
    localparam logic [1:0] OP_SET_RSTN = 2'b10;
    localparam logic [1:0] OP_SET_TM   = 2'b11;

    localparam int unsigned CLK_DIV_DEFAULT = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SH_IN    = 3'd1,
        ST_SH_LOW   = 3'd2,
        ST_SH_HIGH  = 3'd3,
        ST_SH_OUT   = 3'd4,
        ST_CAP_LOW  = 3'd5,
        ST_CAP_HIGH = 3'd6
    } scan_state_e;

    // The phase timer counts down to zero inclusive, so a phase of N cycles loads N-1.
    function automatic logic [7:0] phase_load_val(input int unsigned div);
        return 8'(div - 32'd1);
    endfunction

endpackage

// File: rtl/csoc_phase_timer.sv
// Loadable down-counter timing one csoc_clk phase; done is high on the
// last cycle of the phase (count reached zero).
module csoc_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       done_r;

    // Next count: load wins over decrement, and the count saturates at zero
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = load_val;
        end else if (en && (cnt_r != 8'h00)) begin
            cnt_nxt_s = cnt_r - 8'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count and done flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 8'h00;
            done_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_nxt_s;
            done_r <= (cnt_nxt_s == 8'h00);
        end
    end

    assign done = done_r;

endmodule

// File: rtl/csoc_scan_driver.sv
// Pin-level scan sequencer driving the CSoC test pins from parser commands.
// Optional build macro CSOC_SCAN_LOOPBACK_EN adds the lpbk port (sample csoc_data_o).
module csoc_scan_driver
    import csoc_scan_defs::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic             csoc_clk,
    output logic             csoc_rstn,
    output logic             csoc_test_se,
    output logic             csoc_test_tm,
    output logic [7:0]       csoc_data_o,
    input  logic [7:0]       csoc_data_i
`ifdef CSOC_SCAN_LOOPBACK_EN
    ,
    input  logic             lpbk
`endif
);

    localparam logic [7:0]       PHASE_LOAD = phase_load_val(CLK_DIV);
    localparam logic [LEN_W-1:0] LEN_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

    scan_state_e      state_r;
    scan_state_e      state_nxt_s;
    logic [LEN_W-1:0] len_r;
    logic [7:0]       hold_r;
    logic [7:0]       sample_src_s;
    logic             tmr_done_s;
    logic             tmr_en_s;

    logic cmd_take_s, data_load_s, sample_s, clk_rise_s, clk_fall_s;
    logic out_load_s, len_dec_s, tmr_load_s;

    logic       cmd_ready_r, in_ready_r, out_valid_r, busy_r;
    logic       csoc_clk_r, csoc_rstn_r, csoc_test_se_r, csoc_test_tm_r;
    logic [7:0] out_data_r, csoc_data_o_r;

`ifdef CSOC_SCAN_LOOPBACK_EN
    assign sample_src_s = lpbk ? csoc_data_o_r : csoc_data_i;
`else
    assign sample_src_s = csoc_data_i;
`endif

    assign tmr_en_s = (state_r == ST_SH_LOW) || (state_r == ST_SH_HIGH) ||
                      (state_r == ST_CAP_LOW) || (state_r == ST_CAP_HIGH);

    csoc_phase_timer u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (PHASE_LOAD),
        .en       (tmr_en_s),
        .done     (tmr_done_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and one-cycle datapath strobes
    always_comb begin
        state_nxt_s = state_r;
        cmd_take_s  = 1'b0;
        data_load_s = 1'b0;
        sample_s    = 1'b0;
        clk_rise_s  = 1'b0;
        clk_fall_s  = 1'b0;
        out_load_s  = 1'b0;
        len_dec_s   = 1'b0;
        tmr_load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    cmd_take_s = 1'b1;
                    if ((cmd_op == OP_SHIFT) && (cmd_len != LEN_ZERO)) begin
                        state_nxt_s = ST_SH_IN;
                    end else if ((cmd_op == OP_CAPTURE) && (cmd_len != LEN_ZERO)) begin
                        state_nxt_s = ST_CAP_LOW;
                        tmr_load_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SH_IN: begin
                if (in_valid && in_ready_r) begin
                    data_load_s = 1'b1;
                    tmr_load_s  = 1'b1;
                    state_nxt_s = ST_SH_LOW;
                end else begin
                    state_nxt_s = ST_SH_IN;
                end
            end
            ST_SH_LOW: begin
                // Chain output is sampled on the same edge that raises csoc_clk
                if (tmr_done_s) begin
                    clk_rise_s  = 1'b1;
                    sample_s    = 1'b1;
                    tmr_load_s  = 1'b1;
                    state_nxt_s = ST_SH_HIGH;
                end else begin
                    state_nxt_s = ST_SH_LOW;
                end
            end
            ST_SH_HIGH: begin
                if (tmr_done_s) begin
                    clk_fall_s  = 1'b1;
                    state_nxt_s = ST_SH_OUT;
                end else begin
                    state_nxt_s = ST_SH_HIGH;
                end
            end
            ST_SH_OUT: begin
                if (!out_valid_r || out_ready) begin
                    out_load_s  = 1'b1;
                    len_dec_s   = 1'b1;
                    state_nxt_s = (len_r == LEN_ONE) ? ST_IDLE : ST_SH_IN;
                end else begin
                    state_nxt_s = ST_SH_OUT;
                end
            end
            ST_CAP_LOW: begin
                if (tmr_done_s) begin
                    clk_rise_s  = 1'b1;
                    tmr_load_s  = 1'b1;
                    state_nxt_s = ST_CAP_HIGH;
                end else begin
                    state_nxt_s = ST_CAP_LOW;
                end
            end
            ST_CAP_HIGH: begin
                if (tmr_done_s) begin
                    clk_fall_s  = 1'b1;
                    len_dec_s   = 1'b1;
                    tmr_load_s  = 1'b1;
                    state_nxt_s = (len_r == LEN_ONE) ? ST_IDLE : ST_CAP_LOW;
                end else begin
                    state_nxt_s = ST_CAP_HIGH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Command latch, remaining pulse count and static test-mode pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r          <= LEN_ZERO;
            csoc_rstn_r    <= 1'b0;
            csoc_test_tm_r <= 1'b0;
        end else begin
            if (cmd_take_s) begin
                len_r <= cmd_len;
            end else if (len_dec_s) begin
                len_r <= len_r - LEN_ONE;
            end else begin
                len_r <= len_r;
            end
            if (cmd_take_s && (cmd_op == OP_SET_RSTN)) begin
                csoc_rstn_r <= cmd_len[0];
            end
            if (cmd_take_s && (cmd_op == OP_SET_TM)) begin
                csoc_test_tm_r <= cmd_len[0];
            end
        end
    end

    // Scan clock, scan-in slice and scan-out holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csoc_clk_r    <= 1'b0;
            csoc_data_o_r <= 8'h00;
            hold_r        <= 8'h00;
        end else begin
            if (clk_rise_s) begin
                csoc_clk_r <= 1'b1;
            end else if (clk_fall_s) begin
                csoc_clk_r <= 1'b0;
            end else begin
                csoc_clk_r <= csoc_clk_r;
            end
            if (data_load_s) begin
                csoc_data_o_r <= in_data;
            end
            if (sample_s) begin
                hold_r <= sample_src_s;
            end
        end
    end

    // Scan-out byte slot; a pending byte survives command boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
        end else if (out_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= hold_r;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Status and handshake outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_r    <= 1'b1;
            busy_r         <= 1'b0;
            in_ready_r     <= 1'b0;
            csoc_test_se_r <= 1'b0;
        end else begin
            cmd_ready_r    <= (state_nxt_s == ST_IDLE);
            busy_r         <= (state_nxt_s != ST_IDLE);
            in_ready_r     <= (state_nxt_s == ST_SH_IN);
            csoc_test_se_r <= (state_nxt_s == ST_SH_IN)  || (state_nxt_s == ST_SH_LOW) ||
                              (state_nxt_s == ST_SH_HIGH) || (state_nxt_s == ST_SH_OUT);
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign busy         = busy_r;
    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign csoc_clk     = csoc_clk_r;
    assign csoc_rstn    = csoc_rstn_r;
    assign csoc_test_se = csoc_test_se_r;
    assign csoc_test_tm = csoc_test_tm_r;
    assign csoc_data_o  = csoc_data_o_r;

endmodule

// File: tb/tb_csoc_scan_driver.sv
// Scoreboard bench for csoc_scan_driver with a one-pulse-delay scan chain model.
module tb_csoc_scan_driver;

    localparam logic [1:0] OP_SHIFT    = 2'b00;
    localparam logic [1:0] OP_CAPTURE  = 2'b01;
    localparam logic [1:0] OP_SET_RSTN = 2'b10;
    localparam logic [1:0] OP_SET_TM   = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_len = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        busy;
    logic        csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
    logic [7:0]  csoc_data_o;
    logic [7:0]  csoc_data_i;
    logic [7:0]  chain_m = 8'h00;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    int rise_cnt = 0, high_cnt = 0, low_cnt = 0, stable_cnt = 0;
    int se_bad = 0, busy_cnt = 0, ir_cnt = 0, ov_cnt = 0;
    logic prev_clk = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic cap_mode = 1'b0;
    logic shift_mode = 1'b0;

    always #5 clk = ~clk;

    // Chain model: scan-out shows what was shifted in one pulse earlier
    always @(posedge csoc_clk) chain_m <= csoc_data_o;
    assign csoc_data_i = chain_m;

    csoc_scan_driver #(.CLK_DIV(4), .LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn),
        .csoc_test_se(csoc_test_se), .csoc_test_tm(csoc_test_tm),
        .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i)
`ifdef CSOC_SCAN_LOOPBACK_EN
        , .lpbk(1'b0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pin timing, pulse counting and scoreboard pops, all sampled on negedge
    always @(negedge clk) begin
        if (csoc_clk && !prev_clk) begin
            if (cap_mode) chk("cap_low_cycles", low_cnt, 32'd4);
            if (shift_mode) chk("shift_setup_ge4", 32'(stable_cnt >= 4), 32'd1);
            low_cnt = 0;
            high_cnt = 1;
            rise_cnt++;
        end else if (csoc_clk) begin
            high_cnt++;
        end else if (prev_clk) begin
            if (cap_mode) chk("cap_high_cycles", high_cnt, 32'd4);
            high_cnt = 0;
            low_cnt = 1;
        end else if (busy) begin
            low_cnt++;
        end else begin
            low_cnt = 0;
        end
        if (csoc_data_o != prev_data) stable_cnt = 1;
        else stable_cnt++;
        prev_data = csoc_data_o;
        prev_clk = csoc_clk;
        if (shift_mode && busy && !csoc_test_se) se_bad++;
        if (!busy && csoc_test_se) se_bad++;
        if (cap_mode && csoc_test_se) se_bad++;
        if (busy) busy_cnt++;
        if (in_ready) ir_cnt++;
        if (out_valid) ov_cnt++;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got byte %0h, expected no byte", out_data);
            end else begin
                chk("out_byte", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] len);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) chk("in_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || out_valid || exp_q.size() != 0) && n < 1000) begin @(negedge clk); n++; end
        if (busy || out_valid || exp_q.size() != 0) chk("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rise, base_se, base_busy, base_ir, base_ov, n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_csoc_clk", csoc_clk, 32'd0);
        chk("rst_rstn", csoc_rstn, 32'd0);
        chk("rst_se", csoc_test_se, 32'd0);
        chk("rst_tm", csoc_test_tm, 32'd0);
        chk("rst_data_o", csoc_data_o, 32'h00);
        chk("rst_in_ready", in_ready, 32'd0);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_out_data", out_data, 32'h00);
        chk("rst_cmd_ready", cmd_ready, 32'd1);
        chk("rst_busy", busy, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 32'd1);

        // Pin-level commands
        base_busy = busy_cnt;
        send_cmd(OP_SET_RSTN, 16'h0001);
        chk("set_rstn", csoc_rstn, 32'd1);
        send_cmd(OP_SET_TM, 16'h0001);
        chk("set_tm", csoc_test_tm, 32'd1);
        @(negedge clk);
        chk("set_no_busy", busy_cnt - base_busy, 32'd0);

        // SHIFT len=3
        shift_mode = 1'b1;
        base_rise = rise_cnt; base_se = se_bad;
        exp_q.push_back(8'h00); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        send_cmd(OP_SHIFT, 16'd3);
        feed(8'hA5); feed(8'h3C); feed(8'hFF);
        wait_idle();
        shift_mode = 1'b0;
        chk("shift3_pulses", rise_cnt - base_rise, 32'd3);
        chk("shift3_se", se_bad - base_se, 32'd0);

        // SHIFT len=2 with output back-pressure
        out_ready = 1'b0;
        base_rise = rise_cnt;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h81);
        send_cmd(OP_SHIFT, 16'd2);
        feed(8'h81);
        wait_out_valid();
        feed(8'h7E);
        repeat (18) @(negedge clk);
        chk("stall_pulses", rise_cnt - base_rise, 32'd2);
        chk("stall_csoc_clk_low", csoc_clk, 32'd0);
        chk("stall_busy", busy, 32'd1);
        chk("stall_out_valid", out_valid, 32'd1);
        chk("stall_out_data", out_data, 32'hFF);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
        chk("stall_pulses_after", rise_cnt - base_rise, 32'd2);

        // CAPTURE len=2
        cap_mode = 1'b1;
        base_rise = rise_cnt; base_se = se_bad; base_ir = ir_cnt; base_ov = ov_cnt;
        send_cmd(OP_CAPTURE, 16'd2);
        wait_idle();
        cap_mode = 1'b0;
        chk("cap_pulses", rise_cnt - base_rise, 32'd2);
        chk("cap_se_low", se_bad - base_se, 32'd0);
        chk("cap_in_ready_low", ir_cnt - base_ir, 32'd0);
        chk("cap_out_valid_low", ov_cnt - base_ov, 32'd0);
        chk("cap_data_o_hold", csoc_data_o, 32'h7E);

        // Zero-length SHIFT and CAPTURE
        base_rise = rise_cnt; base_ir = ir_cnt;
        send_cmd(OP_SHIFT, 16'd0);
        @(negedge clk);
        chk("shift0_cmd_ready", cmd_ready, 32'd1);
        chk("shift0_busy", busy, 32'd0);
        send_cmd(OP_CAPTURE, 16'd0);
        @(negedge clk);
        chk("cap0_cmd_ready", cmd_ready, 32'd1);
        chk("cap0_busy", busy, 32'd0);
        chk("len0_pulses", rise_cnt - base_rise, 32'd0);
        chk("len0_in_ready", ir_cnt - base_ir, 32'd0);

        // Reset during a SHIFT with a byte pending
        out_ready = 1'b0;
        exp_q.push_back(8'h7E);
        send_cmd(OP_SHIFT, 16'd2);
        feed(8'h11);
        wait_out_valid();
        feed(8'h22);
        n = 0;
        @(negedge clk);
        while (!csoc_clk && n < 200) begin @(negedge clk); n++; end
        chk("midrst_reached_high", csoc_clk, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_csoc_clk", csoc_clk, 32'd0);
        chk("midrst_out_valid", out_valid, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_cmd_ready", cmd_ready, 32'd1);
        chk("midrst_se", csoc_test_se, 32'd0);
        chk("midrst_rstn", csoc_rstn, 32'd0);
        chk("midrst_data_o", csoc_data_o, 32'h00);
        exp_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_midrst_out_valid", out_valid, 32'd0);
        chk("post_midrst_in_ready", in_ready, 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
